cw310_usb_reg_fe: RTL and testbench

USB register front end for the CW310 FPGA: converts the SAM3U external-memory bus (8-bit data, `usb_addr`, active-low strobes) into the byte-wide register bus consumed by the register block (`reg_address`, `reg_bytecnt`, `reg_read`, `reg_write`, `reg_addrvalid`, `write_data`, `read_data`). It sits directly upstream of the register block and owns bus timing, byte-count auto-increment and read-data return.

---
 rtl/cw310_reg_fe_pkg.sv | 19 +
 rtl/cw310_usb_reg_fe_if.sv | 26 ++
 rtl/cw310_usb_strobe_sync.sv | 31 +++
 rtl/cw310_usb_reg_fe.sv | 200 ++++++++++++++++++++
 tb/tb_cw310_usb_reg_fe.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cw310_reg_fe_pkg.sv
// Shared definitions for the CW310 USB register front end: FSM state encoding,
// default bus geometry and strobe polarity.
package cw310_reg_fe_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT   = 21;
  localparam int unsigned BYTECNT_SIZE_DEFAULT = 7;

  // SAM3U strobes (cen, alen, rdn, wrn) are all active-low.
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWrite,
    StRead
  } fe_state_e;

endpackage

// File: rtl/cw310_usb_reg_fe_if.sv
// SAM3U external-memory bus as seen by the FPGA. master = host side,
// slave = register front end.
interface cw310_usb_reg_fe_if #(
  parameter int unsigned pADDR_WIDTH = 21
) ();

  logic [7:0]             usb_din;
  logic [7:0]             usb_dout;
  logic                   usb_isout;
  logic [pADDR_WIDTH-1:0] usb_addr;
  logic                   usb_alen;
  logic                   usb_cen;
  logic                   usb_rdn;
  logic                   usb_wrn;

  modport master (
    output usb_din, usb_addr, usb_alen, usb_cen, usb_rdn, usb_wrn,
    input  usb_dout, usb_isout
  );

  modport slave (
    input  usb_din, usb_addr, usb_alen, usb_cen, usb_rdn, usb_wrn,
    output usb_dout, usb_isout
  );

endinterface

// File: rtl/cw310_usb_strobe_sync.sv
// Two-stage register for one active-low strobe with single-cycle fall/rise
// pulses derived from the registered copies only.
module cw310_usb_strobe_sync
  import cw310_reg_fe_pkg::*;
(
  input  logic usb_clk,
  input  logic reset_n,
  input  logic strobe_n,
  output logic s1,
  output logic fall,
  output logic rise
);

  logic s1_q, s2_q;

  // Stages reset to the inactive level so reset release never looks like an edge.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      s1_q <= STROBE_IDLE;
      s2_q <= STROBE_IDLE;
    end else begin
      s1_q <= strobe_n;
      s2_q <= s1_q;
    end
  end

  assign s1   = s1_q;
  assign fall = (s1_q == STROBE_ACTIVE) && (s2_q == STROBE_IDLE);
  assign rise = (s1_q == STROBE_IDLE) && (s2_q == STROBE_ACTIVE);

endmodule

// File: rtl/cw310_usb_reg_fe.sv
// USB register front end: SAM3U external-memory bus to byte-wide register bus.
// Optional build macro CW310_REG_FE_ERR_EN enables the sticky O_proto_err flag.
module cw310_usb_reg_fe
  import cw310_reg_fe_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int unsigned pBYTECNT_SIZE = BYTECNT_SIZE_DEFAULT
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_n,
  cw310_usb_reg_fe_if.slave                      usb,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  output logic [7:0]                             write_data,
  input  logic [7:0]                             read_data,
  output logic                                   reg_read,
  output logic                                   reg_write,
  output logic                                   reg_addrvalid,
  output logic                                   O_proto_err
);

  localparam int unsigned RegAddrW = pADDR_WIDTH - pBYTECNT_SIZE;

  logic                   cen_s1, alen_s1;
  logic [pADDR_WIDTH-1:0] addr_s1;
  logic [7:0]             din_s1;
  logic                   rd_s1, rd_fall, rd_rise;
  logic                   wr_s1, wr_fall, wr_rise;

  fe_state_e              state_q, state_d;
  logic [RegAddrW-1:0]    addr_q, addr_d;
  logic [pBYTECNT_SIZE-1:0] cnt_q, cnt_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [7:0]             dout_q, dout_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   valid_q, valid_d;
  logic                   isout_q, isout_d;

  // Stage-1 capture of the non-strobe bus pins.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      cen_s1  <= STROBE_IDLE;
      alen_s1 <= STROBE_IDLE;
      addr_s1 <= '0;
      din_s1  <= '0;
    end else begin
      cen_s1  <= usb.usb_cen;
      alen_s1 <= usb.usb_alen;
      addr_s1 <= usb.usb_addr;
      din_s1  <= usb.usb_din;
    end
  end

  cw310_usb_strobe_sync u_rdn_sync (
    .usb_clk  (usb_clk),
    .reset_n  (reset_n),
    .strobe_n (usb.usb_rdn),
    .s1       (rd_s1),
    .fall     (rd_fall),
    .rise     (rd_rise)
  );

  cw310_usb_strobe_sync u_wrn_sync (
    .usb_clk  (usb_clk),
    .reset_n  (reset_n),
    .strobe_n (usb.usb_wrn),
    .s1       (wr_s1),
    .fall     (wr_fall),
    .rise     (wr_rise)
  );

  // FSM state and all register-bus outputs.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      isout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      read_q  <= read_d;
      write_q <= write_d;
      valid_q <= valid_d;
      isout_q <= isout_d;
    end
  end

  // Next-state logic; cen deassertion aborts any state without a bytecnt step.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    read_d  = read_q;
    write_d = 1'b0;
    valid_d = valid_q;
    isout_d = isout_q;

    if (cen_s1 != STROBE_ACTIVE) begin
      state_d = StIdle;
      read_d  = 1'b0;
      valid_d = 1'b0;
      isout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (alen_s1 == STROBE_ACTIVE) begin
            addr_d  = addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
            cnt_d   = addr_s1[pBYTECNT_SIZE-1:0];
            valid_d = 1'b1;
            state_d = StAddr;
          end
        end
        StAddr: begin
          if (alen_s1 == STROBE_ACTIVE) begin
            addr_d = addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
            cnt_d  = addr_s1[pBYTECNT_SIZE-1:0];
          end
          // Write takes priority if both strobes fall together.
          if (wr_fall) begin
            wdata_d = din_s1;
            write_d = 1'b1;
            state_d = StWrite;
          end else if (rd_fall) begin
            read_d  = 1'b1;
            isout_d = 1'b1;
            state_d = StRead;
          end
        end
        StWrite: begin
          if (wr_rise) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StAddr;
          end
        end
        StRead: begin
          dout_d = read_data;
          if (rd_rise) begin
            read_d  = 1'b0;
            isout_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            state_d = StAddr;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign reg_address   = addr_q;
  assign reg_bytecnt   = cnt_q;
  assign write_data    = wdata_q;
  assign reg_read      = read_q;
  assign reg_write     = write_q;
  assign reg_addrvalid = valid_q;
  assign usb.usb_dout  = dout_q;
  assign usb.usb_isout = isout_q;

`ifdef CW310_REG_FE_ERR_EN
  logic err_q, err_d;

  // Sticky flag: both strobes low together, or a strobe falling while idle.
  always_comb begin
    err_d = err_q;
    if ((rd_s1 == STROBE_ACTIVE) && (wr_s1 == STROBE_ACTIVE)) begin
      err_d = 1'b1;
    end
    if ((state_q == StIdle) && (rd_fall || wr_fall)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign O_proto_err = err_q;
`else
  logic unused_strobe_s1;
  assign unused_strobe_s1 = rd_s1 ^ wr_s1;
  assign O_proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cw310_usb_reg_fe.sv
// Self-checking bench: host-level transactions against a byte-addressable
// memory model of the front end plus register block.
module tb_cw310_usb_reg_fe;

  localparam int AW = 21;
  localparam int BC = 7;
  localparam int RW = AW - BC;

  logic          usb_clk = 1'b0;
  logic          reset_n;
  logic [RW-1:0] reg_address;
  logic [BC-1:0] reg_bytecnt;
  logic [7:0]    write_data;
  logic [7:0]    read_data;
  logic          reg_read, reg_write, reg_addrvalid, O_proto_err;

  always #5 usb_clk = ~usb_clk;

  cw310_usb_reg_fe_if #(.pADDR_WIDTH(AW)) usb ();

  cw310_usb_reg_fe #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) dut (
    .usb_clk       (usb_clk),
    .reset_n       (reset_n),
    .usb           (usb),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .O_proto_err   (O_proto_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Register block stand-in: 16 blocks of 128 bytes, selected by low address bits.
  logic [7:0] regmem [0:2047];
  bit         init_done;
  bit         rd_from_cnt;

  always @(posedge usb_clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) regmem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (reg_write) begin
      regmem[{reg_address[3:0], reg_bytecnt}] <= write_data;
    end
  end

  always_comb begin
    read_data = 8'h00;
    if (rd_from_cnt) read_data = {1'b0, reg_bytecnt};
    else             read_data = regmem[{reg_address[3:0], reg_bytecnt}];
  end

  // Reference model: memory keyed by host byte address, cursor within a block.
  logic [7:0]  ref_mem [0:2047];
  int unsigned m_block;
  int unsigned m_cnt;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [BC-1:0] c;
    logic [7:0]    d;
  } wr_t;
  wr_t exp_wr_q[$];

  function automatic int ref_idx();
    return int'((m_block % 16) * 128 + m_cnt);
  endfunction

  // Per-cycle compare: isout tracks reg_read; every write pulse is single and expected.
  bit prev_wr = 1'b0;
  always @(negedge usb_clk) begin
    wr_t w;
    check("isout_vs_read", usb.usb_isout, reg_read);
    if (reg_write === 1'b1) begin
      check("write_pulse_single", prev_wr, 1'b0);
      if (exp_wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h cnt 0x%0h data 0x%0h, required none",
                 reg_address, reg_bytecnt, write_data);
      end else begin
        w = exp_wr_q.pop_front();
        check("mon_wr_addr", reg_address, w.a);
        check("mon_wr_cnt", reg_bytecnt, w.c);
        check("mon_wr_data", write_data, w.d);
      end
    end
    prev_wr = (reg_write === 1'b1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge usb_clk);
      #1;
    end
  endtask

  task automatic push_write(input logic [7:0] d);
    wr_t w;
    w.a = RW'(m_block);
    w.c = BC'(m_cnt);
    w.d = d;
    exp_wr_q.push_back(w);
    ref_mem[ref_idx()] = d;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a);
    usb.usb_addr = a;
    usb.usb_cen  = 1'b0;
    usb.usb_alen = 1'b0;
    m_block = int'(a >> BC);
    m_cnt   = int'(a % 128);
    tick(1);
    check("addrvalid_early", reg_addrvalid, 1'b0);
    tick(1);
    check("addrvalid", reg_addrvalid, 1'b1);
    check("addr_latch", reg_address, m_block);
    check("cnt_latch", reg_bytecnt, m_cnt);
    usb.usb_alen = 1'b1;
    tick(1);
  endtask

  task automatic host_write(input logic [7:0] d, input int low, input int gap);
    usb.usb_din = d;
    usb.usb_wrn = 1'b0;
    push_write(d);
    tick(2);
    check("reg_write_rise", reg_write, 1'b1);
    check("write_data", write_data, d);
    usb.usb_din = 8'($urandom);
    tick(1);
    check("reg_write_fall", reg_write, 1'b0);
    tick(low - 3);
    usb.usb_wrn = 1'b1;
    tick(1);
    check("cnt_not_early_w", reg_bytecnt, m_cnt);
    m_cnt = (m_cnt + 1) % 128;
    tick(1);
    check("cnt_inc_w", reg_bytecnt, m_cnt);
    check("write_data_held", write_data, d);
    tick(gap - 2);
  endtask

  task automatic host_read(input int low, input int gap, output logic [7:0] got);
    logic [7:0] exp;
    exp = rd_from_cnt ? 8'(m_cnt) : ref_mem[ref_idx()];
    usb.usb_rdn = 1'b0;
    tick(1);
    check("reg_read_early", reg_read, 1'b0);
    tick(1);
    check("reg_read_rise", reg_read, 1'b1);
    tick(1);
    check("dout_first", usb.usb_dout, exp);
    tick(low - 3);
    got = usb.usb_dout;
    check("dout_host", got, exp);
    usb.usb_rdn = 1'b1;
    tick(1);
    check("reg_read_hold", reg_read, 1'b1);
    m_cnt = (m_cnt + 1) % 128;
    tick(1);
    check("reg_read_fall", reg_read, 1'b0);
    check("cnt_inc_r", reg_bytecnt, m_cnt);
    tick(gap - 2);
  endtask

  task automatic end_txn();
    usb.usb_cen  = 1'b1;
    usb.usb_alen = 1'b1;
    tick(2);
    check("end_addrvalid", reg_addrvalid, 1'b0);
    check("end_reg_read", reg_read, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, reg_address, 0);
    check({tag, "_cnt"}, reg_bytecnt, 0);
    check({tag, "_wdata"}, write_data, 0);
    check({tag, "_dout"}, usb.usb_dout, 0);
    check({tag, "_read"}, reg_read, 0);
    check({tag, "_write"}, reg_write, 0);
    check({tag, "_valid"}, reg_addrvalid, 0);
    check({tag, "_isout"}, usb.usb_isout, 0);
    check({tag, "_err"}, O_proto_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] burst_exp [4];
    logic       err_exp;
    int         nops;
    logic [AW-1:0] a;

    burst_exp[0] = 8'h7E; burst_exp[1] = 8'h7F; burst_exp[2] = 8'h00; burst_exp[3] = 8'h01;
`ifdef CW310_REG_FE_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);

    usb.usb_cen  = 1'b1;
    usb.usb_alen = 1'b1;
    usb.usb_rdn  = 1'b1;
    usb.usb_wrn  = 1'b1;
    usb.usb_din  = 8'h00;
    usb.usb_addr = '0;
    rd_from_cnt  = 1'b0;
    reset_n      = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // Single write at 0x000A03.
    addr_phase(21'h000A03);
    check("t1_addr_lit", reg_address, 'h14);
    check("t1_cnt_lit", reg_bytecnt, 3);
    host_write(8'h5A, 3, 2);
    check("t1_wdata_lit", write_data, 8'h5A);
    check("t1_cnt_after", reg_bytecnt, 4);
    end_txn();

    // Burst read across the 127 -> 0 wrap with read_data = bytecnt.
    rd_from_cnt = 1'b1;
    addr_phase(21'h000A7E);
    for (int k = 0; k < 4; k++) begin
      host_read(4, 2, got);
      check("t2_burst_lit", got, burst_exp[k]);
      check("t2_addr_stays", reg_address, 'h14);
    end
    end_txn();
    rd_from_cnt = 1'b0;

    // cen deasserted while rdn is still low.
    addr_phase(21'h000A10);
    usb.usb_rdn = 1'b0;
    tick(3);
    check("t3_read_on", reg_read, 1'b1);
    usb.usb_cen = 1'b1;
    tick(1);
    check("t3_read_still", reg_read, 1'b1);
    tick(1);
    check("t3_read_off", reg_read, 1'b0);
    check("t3_isout_off", usb.usb_isout, 1'b0);
    check("t3_valid_off", reg_addrvalid, 1'b0);
    check("t3_cnt", reg_bytecnt, 'h10);
    usb.usb_rdn = 1'b1;
    tick(3);
    check("t3_cnt_no_inc", reg_bytecnt, 'h10);
    check("t3_no_err", O_proto_err, 1'b0);

    // Reset in the middle of a write.
    addr_phase(21'h000B05);
    usb.usb_din = 8'hC3;
    usb.usb_wrn = 1'b0;
    push_write(8'hC3);
    tick(2);
    check("t4_write_on", reg_write, 1'b1);
    reset_n = 1'b0;
    tick(1);
    check_all_zero("t4_reset");
    usb.usb_wrn  = 1'b1;
    usb.usb_cen  = 1'b1;
    usb.usb_alen = 1'b1;
    reset_n      = 1'b1;
    tick(2);
    addr_phase(21'h000080);
    check("t4_addr_lit", reg_address, 'h01);
    check("t4_cnt_lit", reg_bytecnt, 0);
    host_write(8'h3C, 3, 2);
    end_txn();

    // rdn and wrn fall together: write wins.
    addr_phase(21'h000A20);
    usb.usb_din = 8'h99;
    usb.usb_rdn = 1'b0;
    usb.usb_wrn = 1'b0;
    push_write(8'h99);
    tick(2);
    check("t5_write_on", reg_write, 1'b1);
    check("t5_read_off", reg_read, 1'b0);
    tick(1);
    check("t5_read_off2", reg_read, 1'b0);
    check("t5_err", O_proto_err, err_exp);
    usb.usb_wrn = 1'b1;
    tick(2);
    check("t5_cnt", reg_bytecnt, 'h21);
    usb.usb_rdn = 1'b1;
    tick(3);
    check("t5_read_never", reg_read, 1'b0);
    check("t5_cnt_hold", reg_bytecnt, 'h21);
    check("t5_err_sticky", O_proto_err, err_exp);
    end_txn();
    check("t5_err_after_idle", O_proto_err, err_exp);
    reset_n = 1'b0;
    tick(1);
    check("t5_err_cleared", O_proto_err, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Randomized transactions: mixed writes and reads, some near the wrap.
    for (int t = 0; t < 40; t++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a[BC-1:0] = BC'(124 + $urandom_range(0, 3));
      addr_phase(a);
      nops = int'($urandom_range(1, 6));
      for (int k = 0; k < nops; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          host_write(8'($urandom), int'($urandom_range(3, 5)), int'($urandom_range(2, 4)));
        end else begin
          host_read(int'($urandom_range(4, 6)), int'($urandom_range(2, 4)), got);
        end
      end
      end_txn();
      tick(int'($urandom_range(0, 3)));
    end

    check("final_no_err", O_proto_err, 1'b0);
    check("write_queue_drained", exp_wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
